// File: rtl/qtable_pkg.sv
// Shared constants, state encoding and entry layout for the Q-table updater.
package qtable_pkg;

  localparam logic [2:0] PKT_DATA   = 3'b101;
  localparam logic [2:0] PKT_CH_ADV = 3'b010;

  localparam int unsigned QT_WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN_NBR = 3'd1,
    ST_WR_NBR   = 3'd2,
    ST_SCAN_CH  = 3'd3,
    ST_WR_CH    = 3'd4,
    ST_DONE     = 3'd5
  } qt_state_e;

  // Default-width neighbour entry layout as seen on the read port.
  typedef struct packed {
    logic [QT_WORD_W-1:0] nodeID;
    logic [QT_WORD_W-1:0] clusterID;
    logic [QT_WORD_W-1:0] energy;
    logic [QT_WORD_W-1:0] qValue;
  } nbr_entry_t;

  // Index width for a table of the given depth; at least one bit.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold a count from 0 up to depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/id_table_scan.sv
// Generic ID table: one-entry-per-cycle search for a key, hit/index report,
// and append-if-room. Used for both the neighbour and the cluster-head lists.
module id_table_scan
  import qtable_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           i_key,
  input  logic                       i_scan_clr,
  input  logic                       i_scan_step,
  input  logic                       i_append,
  input  logic [idx_w(DEPTH)-1:0]    i_rd_idx,
  output logic [WIDTH-1:0]           o_rd_id,
  output logic                       o_hit,
  output logic                       o_last,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [idx_w(DEPTH)-1:0]    o_idx,
  output logic [cnt_w(DEPTH)-1:0]    o_count
);

  localparam int unsigned IW = idx_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_ids [DEPTH];
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_count;

  // Scan pointer and append storage; append is ignored once the table is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_ids[i] <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      if (i_scan_clr) begin
        r_idx <= '0;
      end else if (i_scan_step) begin
        r_idx <= r_idx + 1'b1;
      end
      if (i_append && !o_full) begin
        r_ids[r_count[IW-1:0]] <= i_key;
        r_count                <= r_count + 1'b1;
      end
    end
  end

  // Compare at the scan pointer, status flags and the combinational read port.
  always_comb begin
    o_hit   = (r_ids[r_idx] == i_key);
    o_last  = (CW'(r_idx) == (r_count - 1'b1));
    o_empty = (r_count == '0);
    o_full  = (r_count == CW'(DEPTH));
    o_idx   = r_idx;
    o_count = r_count;
    o_rd_id = (32'(i_rd_idx) < DEPTH) ? r_ids[i_rd_idx] : '0;
  end

endmodule

// File: rtl/qtable_update_v4.sv
// Neighbour / known-cluster-head table updater. Sequences two ID scanners and
// owns the neighbour payload (cluster ID, energy, Q-value).
module qtable_update_v4
  import qtable_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned MAX_NBR    = 16,
  parameter int unsigned MAX_CH     = 8
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          en,
  input  logic [WORD_WIDTH-1:0]         fSourceID,
  input  logic [WORD_WIDTH-1:0]         fClusterID,
  input  logic [WORD_WIDTH-1:0]         fEnergyLeft,
  input  logic [WORD_WIDTH-1:0]         fQValue,
  input  logic [2:0]                    fPacketType,
  input  logic [idx_w(MAX_NBR)-1:0]     rd_nbr_idx,
  input  logic [idx_w(MAX_CH)-1:0]      rd_ch_idx,
  output logic [WORD_WIDTH-1:0]         rd_nodeID,
  output logic [WORD_WIDTH-1:0]         rd_clusterID,
  output logic [WORD_WIDTH-1:0]         rd_energy,
  output logic [WORD_WIDTH-1:0]         rd_qValue,
  output logic [WORD_WIDTH-1:0]         rd_knownCH,
  output logic [WORD_WIDTH-1:0]         neighborCount,
  output logic [WORD_WIDTH-1:0]         knownCHCount,
  output logic                          busy,
  output logic                          done,
  output logic                          nbr_drop,
  output logic                          ch_drop
);

  localparam int unsigned NIW = idx_w(MAX_NBR);
  localparam int unsigned CIW = idx_w(MAX_CH);
  localparam int unsigned NCW = cnt_w(MAX_NBR);
  localparam int unsigned CCW = cnt_w(MAX_CH);

  qt_state_e             r_state;
  logic [WORD_WIDTH-1:0] r_src, r_cid, r_energy, r_q;
  logic [2:0]            r_type;
  logic                  r_nbr_hit, r_ch_hit, r_nbr_drop, r_ch_drop;
  logic                  r_done, r_nbr_drop_o, r_ch_drop_o;
  logic [WORD_WIDTH-1:0] r_tcid    [MAX_NBR];
  logic [WORD_WIDTH-1:0] r_tenergy [MAX_NBR];
  logic [WORD_WIDTH-1:0] r_tq      [MAX_NBR];

  logic                  w_scan_clr, w_nbr_step, w_ch_step, w_nbr_append, w_ch_append;
  logic                  w_nbr_hit, w_nbr_last, w_nbr_empty, w_nbr_full;
  logic                  w_ch_hit, w_ch_last, w_ch_empty, w_ch_full;
  logic                  w_qualify;
  logic [NIW-1:0]        w_nbr_idx;
  logic [CIW-1:0]        w_ch_idx_unused;
  logic [NCW-1:0]        w_nbr_cnt;
  logic [CCW-1:0]        w_ch_cnt;

  id_table_scan #(.DEPTH(MAX_NBR), .WIDTH(WORD_WIDTH)) u_nbr_scan (
    .clk        (clk),
    .rst        (nrst),
    .i_key      (r_src),
    .i_scan_clr (w_scan_clr),
    .i_scan_step(w_nbr_step),
    .i_append   (w_nbr_append),
    .i_rd_idx   (rd_nbr_idx),
    .o_rd_id    (rd_nodeID),
    .o_hit      (w_nbr_hit),
    .o_last     (w_nbr_last),
    .o_empty    (w_nbr_empty),
    .o_full     (w_nbr_full),
    .o_idx      (w_nbr_idx),
    .o_count    (w_nbr_cnt)
  );

  id_table_scan #(.DEPTH(MAX_CH), .WIDTH(WORD_WIDTH)) u_ch_scan (
    .clk        (clk),
    .rst        (nrst),
    .i_key      (r_src),
    .i_scan_clr (w_scan_clr),
    .i_scan_step(w_ch_step),
    .i_append   (w_ch_append),
    .i_rd_idx   (rd_ch_idx),
    .o_rd_id    (rd_knownCH),
    .o_hit      (w_ch_hit),
    .o_last     (w_ch_last),
    .o_empty    (w_ch_empty),
    .o_full     (w_ch_full),
    .o_idx      (w_ch_idx_unused),
    .o_count    (w_ch_cnt)
  );

  // Scanner control and output decode from the current state.
  always_comb begin
    w_scan_clr    = (r_state == ST_IDLE) && en;
    w_nbr_step    = (r_state == ST_SCAN_NBR) && !w_nbr_hit && !w_nbr_last;
    w_ch_step     = (r_state == ST_SCAN_CH) && !w_ch_hit && !w_ch_last;
    // Scanners drop the append themselves when full.
    w_nbr_append  = (r_state == ST_WR_NBR) && !r_nbr_hit;
    w_ch_append   = (r_state == ST_WR_CH) && !r_ch_hit;
    w_qualify     = (r_type == PKT_CH_ADV) || (r_src == r_cid);
    busy          = (r_state != ST_IDLE);
    done          = r_done;
    nbr_drop      = r_nbr_drop_o;
    ch_drop       = r_ch_drop_o;
    neighborCount = WORD_WIDTH'(w_nbr_cnt);
    knownCHCount  = WORD_WIDTH'(w_ch_cnt);
    if (32'(rd_nbr_idx) < MAX_NBR) begin
      rd_clusterID = r_tcid[rd_nbr_idx];
      rd_energy    = r_tenergy[rd_nbr_idx];
      rd_qValue    = r_tq[rd_nbr_idx];
    end else begin
      rd_clusterID = '0;
      rd_energy    = '0;
      rd_qValue    = '0;
    end
  end

  // Update FSM, packet holding registers, payload storage and output pulses.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state      <= ST_IDLE;
      r_src        <= '0;
      r_cid        <= '0;
      r_energy     <= '0;
      r_q          <= '0;
      r_type       <= '0;
      r_nbr_hit    <= 1'b0;
      r_ch_hit     <= 1'b0;
      r_nbr_drop   <= 1'b0;
      r_ch_drop    <= 1'b0;
      r_done       <= 1'b0;
      r_nbr_drop_o <= 1'b0;
      r_ch_drop_o  <= 1'b0;
      for (int i = 0; i < int'(MAX_NBR); i++) begin
        r_tcid[i]    <= '0;
        r_tenergy[i] <= '0;
        r_tq[i]      <= '0;
      end
    end else begin
      // Pulses are registered out of DONE, so they appear the cycle after it.
      r_done       <= (r_state == ST_DONE);
      r_nbr_drop_o <= (r_state == ST_DONE) && r_nbr_drop;
      r_ch_drop_o  <= (r_state == ST_DONE) && r_ch_drop;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_src      <= fSourceID;
            r_cid      <= fClusterID;
            r_energy   <= fEnergyLeft;
            r_q        <= fQValue;
            r_type     <= fPacketType;
            r_nbr_hit  <= 1'b0;
            r_ch_hit   <= 1'b0;
            r_nbr_drop <= 1'b0;
            r_ch_drop  <= 1'b0;
            r_state    <= w_nbr_empty ? ST_WR_NBR : ST_SCAN_NBR;
          end
        end
        ST_SCAN_NBR: begin
          // Pointer is held on a hit so it names the entry to overwrite.
          if (w_nbr_hit) begin
            r_nbr_hit <= 1'b1;
            r_state   <= ST_WR_NBR;
          end else if (w_nbr_last) begin
            r_state <= ST_WR_NBR;
          end
        end
        ST_WR_NBR: begin
          if (r_nbr_hit) begin
            r_tcid[w_nbr_idx]    <= r_cid;
            r_tenergy[w_nbr_idx] <= r_energy;
            r_tq[w_nbr_idx]      <= r_q;
          end else if (!w_nbr_full) begin
            r_tcid[w_nbr_cnt[NIW-1:0]]    <= r_cid;
            r_tenergy[w_nbr_cnt[NIW-1:0]] <= r_energy;
            r_tq[w_nbr_cnt[NIW-1:0]]      <= r_q;
          end else begin
            r_nbr_drop <= 1'b1;
          end
          if (!w_qualify)      r_state <= ST_DONE;
          else if (w_ch_empty) r_state <= ST_WR_CH;
          else                 r_state <= ST_SCAN_CH;
        end
        ST_SCAN_CH: begin
          if (w_ch_hit) begin
            r_ch_hit <= 1'b1;
            r_state  <= ST_WR_CH;
          end else if (w_ch_last) begin
            r_state <= ST_WR_CH;
          end
        end
        ST_WR_CH: begin
          if (!r_ch_hit && w_ch_full) r_ch_drop <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qtable_update_v4.sv
// Self-checking bench for qtable_update_v4 against a list-based table model.
module tb_qtable_update_v4;
  import qtable_pkg::*;

  localparam int unsigned W    = 16;
  localparam int unsigned MAXN = 6;
  localparam int unsigned MAXC = 3;
  localparam int unsigned NIW  = idx_w(MAXN);
  localparam int unsigned CIW  = idx_w(MAXC);

  logic           clk = 1'b0;
  logic           nrst, en;
  logic [W-1:0]   f_src, f_cid, f_eng, f_q;
  logic [2:0]     f_type;
  logic [NIW-1:0] rd_nbr_idx;
  logic [CIW-1:0] rd_ch_idx;
  logic [W-1:0]   rd_nodeID, rd_clusterID, rd_energy, rd_qValue, rd_knownCH;
  logic [W-1:0]   neighborCount, knownCHCount;
  logic           busy, done, nbr_drop, ch_drop;

  qtable_update_v4 #(.WORD_WIDTH(W), .MAX_NBR(MAXN), .MAX_CH(MAXC)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .fSourceID    (f_src),
    .fClusterID   (f_cid),
    .fEnergyLeft  (f_eng),
    .fQValue      (f_q),
    .fPacketType  (f_type),
    .rd_nbr_idx   (rd_nbr_idx),
    .rd_ch_idx    (rd_ch_idx),
    .rd_nodeID    (rd_nodeID),
    .rd_clusterID (rd_clusterID),
    .rd_energy    (rd_energy),
    .rd_qValue    (rd_qValue),
    .rd_knownCH   (rd_knownCH),
    .neighborCount(neighborCount),
    .knownCHCount (knownCHCount),
    .busy         (busy),
    .done         (done),
    .nbr_drop     (nbr_drop),
    .ch_drop      (ch_drop)
  );

  always #50 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain lists of neighbours and cluster heads.
  int m_id [MAXN];
  int m_cid[MAXN];
  int m_en [MAXN];
  int m_q  [MAXN];
  int m_ch [MAXC];
  int m_ncnt, m_ccnt;
  bit chk_on = 1'b0;
  int g_lat;
  bit g_nd, g_cd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(MAXN); i++) begin
      m_id[i] = 0; m_cid[i] = 0; m_en[i] = 0; m_q[i] = 0;
    end
    for (int i = 0; i < int'(MAXC); i++) m_ch[i] = 0;
    m_ncnt = 0;
    m_ccnt = 0;
  endtask

  // Counts must match the model whenever no update is in flight.
  always @(negedge clk) begin
    if (chk_on && busy === 1'b0) begin
      chk("nbr_count_idle", neighborCount, m_ncnt);
      chk("ch_count_idle", knownCHCount, m_ccnt);
    end
  end

  task automatic check_tables();
    for (int i = 0; i < m_ncnt; i++) begin
      rd_nbr_idx = NIW'(i);
      #1;
      chk("tbl_nodeID", rd_nodeID, m_id[i]);
      chk("tbl_clusterID", rd_clusterID, m_cid[i]);
      chk("tbl_energy", rd_energy, m_en[i]);
      chk("tbl_qValue", rd_qValue, m_q[i]);
    end
    for (int i = 0; i < m_ccnt; i++) begin
      rd_ch_idx = CIW'(i);
      #1;
      chk("tbl_knownCH", rd_knownCH, m_ch[i]);
    end
  endtask

  // One update: drive, apply the model, then measure latency and flags.
  task automatic do_txn(input int src, input int cid, input int eng, input int q,
                        input logic [2:0] typ, input bit noise);
    int  h, sn, sc, lat, got;
    bit  hit, qual, exp_nd, exp_cd, bad_busy;
    f_src = W'(src); f_cid = W'(cid); f_eng = W'(eng); f_q = W'(q); f_type = typ;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    hit = 1'b0; h = 0;
    for (int i = 0; i < m_ncnt; i++) if (!hit && m_id[i] == src) begin hit = 1'b1; h = i; end
    sn = hit ? h + 1 : m_ncnt;
    exp_nd = 1'b0;
    if (hit) begin
      m_cid[h] = cid; m_en[h] = eng; m_q[h] = q;
    end else if (m_ncnt < int'(MAXN)) begin
      m_id[m_ncnt] = src; m_cid[m_ncnt] = cid; m_en[m_ncnt] = eng; m_q[m_ncnt] = q;
      m_ncnt++;
    end else begin
      exp_nd = 1'b1;
    end
    qual = (typ == 3'b010) || (src == cid);
    sc = 0; exp_cd = 1'b0;
    if (qual) begin
      hit = 1'b0; h = 0;
      for (int i = 0; i < m_ccnt; i++) if (!hit && m_ch[i] == src) begin hit = 1'b1; h = i; end
      sc = hit ? h + 1 : m_ccnt;
      if (!hit) begin
        if (m_ccnt < int'(MAXC)) begin m_ch[m_ccnt] = src; m_ccnt++; end
        else exp_cd = 1'b1;
      end
    end
    lat = 2 + sn + (qual ? sc + 1 : 0);
    got = 0; bad_busy = 1'b0;
    for (int j = 1; j <= lat + int'(MAXN + MAXC) + 8; j++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin got = j; break; end
      if (busy !== 1'b1) bad_busy = 1'b1;
      if (noise && j < lat) begin
        en = 1'($urandom_range(0, 1));
        f_src = W'($urandom_range(1, 9)); f_cid = W'($urandom_range(1, 9));
        f_eng = W'($urandom); f_q = W'($urandom); f_type = 3'($urandom);
      end
    end
    en = 1'b0;
    chk("done_latency", got, lat);
    chk("busy_during_update", bad_busy, 1'b0);
    g_nd = nbr_drop; g_cd = ch_drop; g_lat = got;
    if (got != 0) begin
      chk("busy_at_done", busy, 1'b0);
      chk("nbr_drop", nbr_drop, exp_nd);
      chk("ch_drop", ch_drop, exp_cd);
    end
    check_tables();
  endtask

  initial begin
    bit saw_done;
    model_reset();
    nrst = 1'b1; en = 1'b0;
    f_src = '0; f_cid = '0; f_eng = '0; f_q = '0; f_type = '0;
    rd_nbr_idx = '0; rd_ch_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nbr_drop", nbr_drop, 0);
    chk("rst_ch_drop", ch_drop, 0);
    chk("rst_nbr_count", neighborCount, 0);
    chk("rst_ch_count", knownCHCount, 0);
    chk("rst_entry0", {rd_nodeID, rd_clusterID} | {rd_energy, rd_qValue}, 0);
    chk("rst_ch0", rd_knownCH, 0);
    nrst = 1'b0;
    chk_on = 1'b1;
    @(posedge clk); #1;

    // Hand-computed pins of the model.
    do_txn(1, 2, 16'h8000, 16'h3000, 3'b101, 1'b0);
    chk("t1_latency", g_lat, 2);
    rd_nbr_idx = '0; #1;
    chk("t1_count", neighborCount, 1);
    chk("t1_entry0", {rd_nodeID, rd_clusterID}, 32'h0001_0002);
    chk("t1_entry0_eq", {rd_energy, rd_qValue}, 32'h8000_3000);
    chk("t1_ch_count", knownCHCount, 0);

    do_txn(1, 3, 16'h1800, 16'h2E00, 3'b101, 1'b0);
    chk("t2_latency", g_lat, 3);
    rd_nbr_idx = '0; #1;
    chk("t2_count", neighborCount, 1);
    chk("t2_entry0", {rd_nodeID, rd_clusterID}, 32'h0001_0003);
    chk("t2_entry0_eq", {rd_energy, rd_qValue}, 32'h1800_2E00);

    do_txn(5, 5, 16'h4000, 16'h1000, 3'b101, 1'b0);
    chk("t3a_latency", g_lat, 4);
    rd_ch_idx = '0; #1;
    chk("t3a_counts", {neighborCount, knownCHCount}, 32'h0002_0001);
    chk("t3a_ch0", rd_knownCH, 5);
    do_txn(5, 5, 16'h4100, 16'h1100, 3'b101, 1'b0);
    chk("t3b_latency", g_lat, 6);
    chk("t3b_counts", {neighborCount, knownCHCount}, 32'h0002_0001);
    chk("t3b_ch_drop", g_cd, 0);

    // Fill the neighbour table, overflow it, then update an existing entry.
    for (int i = 0; i < 4; i++) do_txn(100 + i, 0, i, i, 3'b101, 1'b0);
    chk("fill_count", neighborCount, MAXN);
    do_txn(200, 0, 16'h7777, 16'h7777, 3'b101, 1'b0);
    chk("full_drop", g_nd, 1);
    chk("full_latency", g_lat, 2 + int'(MAXN));
    chk("full_count", neighborCount, MAXN);
    do_txn(100, 7, 16'h0ABC, 16'h0DEF, 3'b101, 1'b1);
    chk("full_update_drop", g_nd, 0);

    // Fill and overflow the cluster-head list with advertisements.
    do_txn(1, 9, 16'h1111, 16'h2222, 3'b010, 1'b1);
    do_txn(100, 9, 16'h1234, 16'h2345, 3'b010, 1'b1);
    chk("ch_fill_count", knownCHCount, MAXC);
    do_txn(101, 9, 16'h3333, 16'h4444, 3'b010, 1'b1);
    chk("ch_full_drop", g_cd, 1);
    chk("ch_full_count", knownCHCount, MAXC);

    // Reset in the middle of a neighbour scan, with an ignored en while busy.
    f_src = 16'd50; f_cid = 16'd0; f_type = 3'b101; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    f_src = 16'd51; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    chk("busy_en_ignored_busy", busy, 1);
    chk("busy_en_ignored_count", neighborCount, MAXN);
    chk_on = 1'b0;
    nrst = 1'b1;
    #5;
    chk("midrst_busy", busy, 0);
    chk("midrst_count", {neighborCount, knownCHCount}, 0);
    @(posedge clk); #1;
    nrst = 1'b0;
    model_reset();
    rd_nbr_idx = '0; rd_ch_idx = '0; #1;
    chk("midrst_entry0", {rd_nodeID, rd_clusterID} | {rd_energy, rd_qValue}, 0);
    chk_on = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    chk("midrst_quiet", saw_done, 0);
    do_txn(7, 8, 16'h0100, 16'h0200, 3'b101, 1'b0);
    chk("postrst_latency", g_lat, 2);
    chk("postrst_count", neighborCount, 1);

    // Randomized traffic over a small ID pool so hits, appends and drops mix.
    for (int t = 0; t < 120; t++) begin
      int      s, c;
      logic [2:0] ty;
      s = int'($urandom_range(1, 9));
      c = ($urandom_range(0, 3) == 0) ? s : int'($urandom_range(1, 9));
      case ($urandom_range(0, 2))
        0:       ty = 3'b101;
        1:       ty = 3'b010;
        default: ty = 3'($urandom);
      endcase
      do_txn(s, c, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), ty, 1'b1);
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
